// File: rtl/immgen.sv
// RV32I immediate generator: decodes the instruction format, assembles the
// sign-extended immediate, and keeps a registered copy for the next stage.
module immgen #(
    parameter int unsigned XLEN       = 32,
    parameter bit          SHAMT_ZEXT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    input  logic            in_valid,
    output logic [XLEN-1:0] imm_q,
    output logic [2:0]      fmt_q,
    output logic            illegal_q,
    output logic            valid_q
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_OPIMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_MISCMEM  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_OP       = 7'b0110011;

    logic       sgn;
    logic [6:0] opcode;
    logic       is_shift;

    assign sgn    = instr[31];
    assign opcode = instr[6:0];
    // funct3 001 (SLLI) and 101 (SRLI/SRAI) share instr[13:12] == 01
    assign is_shift = SHAMT_ZEXT && (opcode == OP_OPIMM) && (instr[13:12] == 2'b01);

    // Format decode and immediate assembly; unrecognised opcodes give NONE/0.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_MISCMEM, OP_SYSTEM: begin
                fmt     = FMT_I;
                illegal = 1'b0;
                if (is_shift) begin
                    // shamt only; bit 30 (SRAI select) must not leak in
                    imm = {27'b0, instr[24:20]};
                end else begin
                    imm = {{20{sgn}}, instr[31:20]};
                end
            end
            OP_STORE: begin
                fmt     = FMT_S;
                illegal = 1'b0;
                imm     = {{20{sgn}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt     = FMT_B;
                illegal = 1'b0;
                imm     = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt     = FMT_U;
                illegal = 1'b0;
                imm     = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt     = FMT_J;
                illegal = 1'b0;
                imm     = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_OP: begin
                fmt     = FMT_R;
                illegal = 1'b0;
                imm     = '0;
            end
            default: begin
                imm     = '0;
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    // Pipeline register: reset beats capture; fields hold when not capturing.
    always_ff @(posedge clk) begin
        if (reset) begin
            imm_q     <= '0;
            fmt_q     <= FMT_NONE;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else if (in_valid) begin
            imm_q     <= imm;
            fmt_q     <= fmt;
            illegal_q <= illegal;
            valid_q   <= 1'b1;
        end else begin
            valid_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_immgen.sv
// Self-checking bench for immgen: random instructions against an arithmetic
// reference model, with a scoreboard for the registered path.
module tb_immgen;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
    logic        in_valid;
    logic [31:0] imm_q;
    logic [2:0]  fmt_q;
    logic        illegal_q;
    logic        valid_q;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        int          kind;   // 0 reset, 1 load, 2 hold
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } entry_t;

    entry_t sb[$];

    immgen #(.XLEN(32), .SHAMT_ZEXT(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .imm       (imm),
        .fmt       (fmt),
        .illegal   (illegal),
        .in_valid  (in_valid),
        .imm_q     (imm_q),
        .fmt_q     (fmt_q),
        .illegal_q (illegal_q),
        .valid_q   (valid_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (instr 0x%08h)", name, act, exp, instr);
        end
    endtask

    // Reference: fields weighted by their bit positions, sign applied by subtraction.
    function automatic void model(input logic [31:0] i, output logic [31:0] e_imm,
                                  output logic [2:0] e_fmt, output logic e_ill);
        int v;
        logic [6:0] op;
        logic [2:0] f3;
        op = i[6:0];
        f3 = i[14:12];
        v = 0;
        e_ill = 1'b0;
        if (op == 7'h03 || op == 7'h13 || op == 7'h67 || op == 7'h0F || op == 7'h73) begin
            e_fmt = 3'd1;
            if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
                v = int'(i[24:20]);
            end else begin
                v = int'(i[30:20]);
                if (i[31]) v = v - 2048;
            end
        end else if (op == 7'h23) begin
            e_fmt = 3'd2;
            v = int'(i[30:25]) * 32 + int'(i[11:7]);
            if (i[31]) v = v - 2048;
        end else if (op == 7'h63) begin
            e_fmt = 3'd3;
            v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            if (i[31]) v = v - 4096;
        end else if (op == 7'h37 || op == 7'h17) begin
            e_fmt = 3'd4;
            v = int'(i & 32'hFFFF_F000);
        end else if (op == 7'h6F) begin
            e_fmt = 3'd5;
            v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            if (i[31]) v = v - 1048576;
        end else if (op == 7'h33) begin
            e_fmt = 3'd0;
        end else begin
            e_fmt = 3'd7;
            e_ill = 1'b1;
        end
        e_imm = 32'(v);
    endfunction

    // Apply one cycle of stimulus, check the combinational outputs, queue the register effect.
    task automatic drive(input logic r, input logic v, input logic [31:0] ins);
        logic [31:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_ill;
        entry_t      e;
        @(negedge clk);
        reset    = r;
        in_valid = v;
        instr    = ins;
        #1;
        model(ins, e_imm, e_fmt, e_ill);
        check("imm", imm, e_imm);
        check("fmt", 32'(fmt), 32'(e_fmt));
        check("illegal", 32'(illegal), 32'(e_ill));
        e.kind = r ? 0 : (v ? 1 : 2);
        e.imm  = e_imm;
        e.fmt  = e_fmt;
        e.ill  = e_ill;
        sb.push_back(e);
    endtask

    // Directed combinational vector with hand-derived expectations.
    task automatic dchk(input logic [31:0] ins, input logic [31:0] x_imm,
                        input logic [2:0] x_fmt, input logic x_ill);
        drive(1'b0, 1'b1, ins);
        check("dir_imm", imm, x_imm);
        check("dir_fmt", 32'(fmt), 32'(x_fmt));
        check("dir_illegal", 32'(illegal), 32'(x_ill));
    endtask

    // Monitor: after every edge, compare registers against the queued expectation.
    initial begin : monitor
        logic [31:0] h_imm;
        logic [2:0]  h_fmt;
        logic        h_ill;
        logic        h_val;
        entry_t      e;
        h_imm = '0;
        h_fmt = 3'd7;
        h_ill = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.kind == 0) begin
                    h_imm = '0; h_fmt = 3'd7; h_ill = 1'b0; h_val = 1'b0;
                end else if (e.kind == 1) begin
                    h_imm = e.imm; h_fmt = e.fmt; h_ill = e.ill; h_val = 1'b1;
                end else begin
                    h_val = 1'b0;
                end
                check("valid_q", 32'(valid_q), 32'(h_val));
                check("imm_q", imm_q, h_imm);
                check("fmt_q", 32'(fmt_q), 32'(h_fmt));
                check("illegal_q", 32'(illegal_q), 32'(h_ill));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [6:0]  ops [11];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        reset    = 1'b1;
        in_valid = 1'b0;
        instr    = '0;

        // Reset held two edges, then a capture, then a hold.
        drive(1'b1, 1'b0, 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h0000_0000);
        drive(1'b0, 1'b1, 32'hFFF0_0093);
        drive(1'b0, 1'b0, 32'h1234_52B7);
        drive(1'b0, 1'b0, 32'h0000_0463);

        // Test-plan combinational vectors.
        dchk(32'h0000_2083, 32'h0000_0000, 3'd1, 1'b0);
        dchk(32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
        dchk(32'hFE20_AE23, 32'hFFFF_FFFC, 3'd2, 1'b0);
        dchk(32'h0000_0463, 32'h0000_0008, 3'd3, 1'b0);
        dchk(32'h1234_52B7, 32'h1234_5000, 3'd4, 1'b0);
        dchk(32'h4030_D093, 32'h0000_0003, 3'd1, 1'b0);
        dchk(32'h0000_0033, 32'h0000_0000, 3'd0, 1'b0);
        dchk(32'h0000_007F, 32'h0000_0000, 3'd7, 1'b1);

        // Reset together with in_valid clears, then capture again.
        drive(1'b1, 1'b1, 32'hFFF0_0093);
        drive(1'b0, 1'b1, 32'hFE20_AE23);

        // Random traffic: mostly legal opcodes, occasional reset mid-stream.
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 10)];
            drive(($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1, w);
        end

        drive(1'b0, 1'b0, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/immgen.md
Name: immgen

Overview:
- RV32I immediate generator for the R4 core decode stage.
- Extracts, sign-extends and assembles the 32-bit immediate of any RV32I instruction word.
- Also reports the instruction format.
- Combinational outputs feed same-cycle decode; a registered copy with valid feeds the next pipeline stage.

Parameters:
- XLEN, 32, immediate/output width (only 32 supported).
- SHAMT_ZEXT, 1, when 1, shift-immediate instructions (SLLI/SRLI/SRAI) output zero-extended shamt instr[24:20]; when 0, they use the plain I-format immediate.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- instr  input  32  instruction word.
- imm  output  32  combinational immediate.
- fmt  output  3  combinational format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7.
- illegal  output  1  combinational; 1 when opcode is not a recognised RV32I opcode.
- in_valid  input  1  capture strobe for registered outputs.
- imm_q  output  32  registered imm.
- fmt_q  output  3  registered fmt.
- illegal_q  output  1  registered illegal.
- valid_q  output  1  registered in_valid.

Behaviour:
- imm, fmt and illegal are purely combinational from instr, with zero latency; they do not depend on clk or reset.
- Opcode decode (instr[6:0]) selects the format:
  - I: 0000011 LOAD, 0010011 OP-IMM, 1100111 JALR, 0001111 MISC-MEM, 1110011 SYSTEM.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111 LUI, 0010111 AUIPC.
  - J: 1101111.
  - R: 0110011 (imm=0).
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
  - Bits [1:0] != 11 are not recognised: NONE/illegal.
- Immediate assembly (s = instr[31], replicated as the sign):
  - I: {20{s}, instr[31:20]}.
  - S: {20{s}, instr[31:25], instr[11:7]}.
  - B: {19{s}, instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {11{s}, instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Shift immediates: when SHAMT_ZEXT=1, OP-IMM with funct3=001 or 101 outputs {27'b0, instr[24:20]}. The funct7 bit 30 (SRAI) is excluded from imm.
- No other field (rd, rs1, rs2, funct3) affects imm except as stated above.
- Registered path, on each rising clk edge:
  - reset=1: imm_q=0, fmt_q=NONE(7), illegal_q=0, valid_q=0. Reset wins over in_valid.
  - reset=0, in_valid=1: imm_q/fmt_q/illegal_q load the combinational values; valid_q=1.
  - reset=0, in_valid=0: imm_q/fmt_q/illegal_q hold; valid_q=0.
- Reset asserted mid-stream clears on the next edge. The first capture is possible on the edge after reset deasserts.
- No X propagation: every opcode maps to a defined output.

Test Plan:
- instr=0x00002083 (LW x1,0(x0)) -> imm=0x00000000, fmt=1, illegal=0.
- instr=0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF, fmt=1. instr=0xFE20AE23 (SW x2,-4(x1)) -> imm=0xFFFFFFFC, fmt=2.
- instr=0x00000463 (BEQ +8) -> imm=0x00000008, fmt=3. instr=0x123452B7 (LUI) -> imm=0x12345000, fmt=4.
- instr=0x4030D093 (SRAI x1,x1,3), SHAMT_ZEXT=1 -> imm=0x00000003. instr=0x00000033 (ADD) -> imm=0, fmt=0. instr=0x0000007F -> fmt=7, illegal=1, imm=0.
- Registered path:
  - Hold reset=1 for 2 edges -> imm_q=0, fmt_q=7, valid_q=0.
  - Deassert, in_valid=1, instr=0xFFF00093 -> next edge imm_q=0xFFFFFFFF, valid_q=1.
  - in_valid=0, instr changed -> imm_q holds, valid_q=0.
- Apply reset=1 and in_valid=1 on the same edge -> registers cleared, valid_q=0.
